// File: rtl/nnrv_wb_pkg.sv
// nnrv_wb_pkg: shared definitions for the nnrv writeback stage.
//   - Load-size encodings carried on i_mem_lsize.
//   - Register index width.
//   - Width of the low address bits used to align load data.
package nnrv_wb_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        LS_BYTE   = 2'd0,
        LS_HALF   = 2'd1,
        LS_WORD   = 2'd2,
        LS_DOUBLE = 2'd3
    } lsize_e;

    // Number of byte-offset bits within one XLEN-wide word.
    function automatic int addr_lo_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/nnrv_wb_ldfmt.sv
// nnrv_wb_ldfmt: combinational load-data formatter.
// Shifts the raw memory word right by the byte offset (zero fill), keeps the
// low 8/16/32/64 bits selected by the load size and sign- or zero-extends the
// kept field to XLEN. On a 32-bit datapath a double-size load acts as a word.
// Ports:
//   i_raw       raw load word from the memory stage
//   i_addr_lo   byte offset of the load within the word
//   i_lsize     load size (LS_BYTE/LS_HALF/LS_WORD/LS_DOUBLE)
//   i_unsigned  1 = zero-extend, 0 = sign-extend
//   o_data      formatted register value
module nnrv_wb_ldfmt import nnrv_wb_pkg::*; #(
    parameter  int XLEN = 64,
    localparam int AW   = addr_lo_w(XLEN)
) (
    input  logic [XLEN-1:0] i_raw,
    input  logic [AW-1:0]   i_addr_lo,
    input  logic [1:0]      i_lsize,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep_mask;
    logic [XLEN-1:0] top_mask;
    logic [6:0]      keep_w;
    logic            sign;

    always_comb begin
        shifted = i_raw >> {i_addr_lo, 3'b000};
        case (i_lsize)
            LS_BYTE: keep_w = 7'd8;
            LS_HALF: keep_w = 7'd16;
            LS_WORD: keep_w = 7'd32;
            default: keep_w = (XLEN > 32) ? 7'd64 : 7'd32;
        endcase
        // Shifting all-ones by the full width yields zero, so a full-width
        // keep needs no special case.
        keep_mask = ~({XLEN{1'b1}} << keep_w);
        // Isolates the most significant kept bit without a variable index.
        top_mask  = keep_mask & ~(keep_mask >> 1);
        sign      = (|(shifted & top_mask)) & ~i_unsigned;
        o_data    = (shifted & keep_mask) | ({XLEN{sign}} & ~keep_mask);
    end

endmodule

// File: rtl/nnrv_wb_ext.sv
// nnrv_wb_ext: registered multi-source writeback stage for the nnrv core.
// Each cycle one result is chosen for the single register-file write port:
//   1. a mem-stage result writing a non-zero rd,
//   2. otherwise the head of the mul/div buffer,
//   3. otherwise, with an empty buffer, an incoming mul/div result (bypass).
// Mul/div results that are accepted but not written immediately are queued in
// a MD_DEPTH-entry FIFO. Results aimed at x0 are accepted and discarded.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_mem_*                 retiring mem-stage instruction and its result
//   i_md_valid/o_md_ready   mul/div handshake; a transfer happens on a cycle
//                           where both are high. o_md_ready depends only on
//                           the buffer occupancy register.
//   i_md_rd, i_md_result    mul/div destination and value
//   o_reg_w_en/_w/_w_reg    registered register-file write port
//   o_md_pending            buffer holds at least one result
//   o_instret               count of cycles with i_mem_valid (wraps)
module nnrv_wb_ext import nnrv_wb_pkg::*; #(
    parameter  int XLEN     = 64,
    parameter  int MD_DEPTH = 2,
    parameter  int CNT_W    = 64,
    localparam int AW       = addr_lo_w(XLEN),
    localparam int PW       = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1,
    localparam int OW       = $clog2(MD_DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mem_valid,
    input  logic                 i_mem_rd_en,
    input  logic [REG_IDX_W-1:0] i_mem_rd,
    input  logic [XLEN-1:0]      i_mem_rd_reg,
    input  logic                 i_mem_load,
    input  logic [1:0]           i_mem_lsize,
    input  logic                 i_mem_lunsigned,
    input  logic [AW-1:0]        i_mem_addr_lo,
    input  logic                 i_md_valid,
    output logic                 o_md_ready,
    input  logic [REG_IDX_W-1:0] i_md_rd,
    input  logic [XLEN-1:0]      i_md_result,
    output logic                 o_reg_w_en,
    output logic [REG_IDX_W-1:0] o_reg_w,
    output logic [XLEN-1:0]      o_reg_w_reg,
    output logic                 o_md_pending,
    output logic [CNT_W-1:0]     o_instret
);

    // Mul/div buffer state
    logic [REG_IDX_W-1:0] buf_rd_q  [MD_DEPTH];
    logic [XLEN-1:0]      buf_res_q [MD_DEPTH];
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [OW-1:0]        count_q, count_d;
    logic                 pending_q, pending_d;

    // Write port and counter state
    logic                 w_en_q, w_en_d;
    logic [REG_IDX_W-1:0] w_idx_q, w_idx_d;
    logic [XLEN-1:0]      w_data_q, w_data_d;
    logic [CNT_W-1:0]     instret_q, instret_d;

    logic [XLEN-1:0]      mem_fmt;
    logic                 buf_empty;
    logic                 buf_full;
    logic                 md_fire;
    logic                 mem_wr;
    logic                 push;
    logic                 pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    nnrv_wb_ldfmt #(.XLEN(XLEN)) u_ldfmt (
        .i_raw      (i_mem_rd_reg),
        .i_addr_lo  (i_mem_addr_lo),
        .i_lsize    (i_mem_lsize),
        .i_unsigned (i_mem_lunsigned),
        .o_data     (mem_fmt)
    );

    assign buf_empty  = (count_q == '0);
    assign buf_full   = (count_q == OW'(MD_DEPTH));
    assign o_md_ready = ~buf_full;
    assign md_fire    = i_md_valid & o_md_ready;
    assign mem_wr     = i_mem_valid & i_mem_rd_en & (i_mem_rd != '0);

    always_comb begin
        w_en_d    = 1'b0;
        w_idx_d   = w_idx_q;
        w_data_d  = w_data_q;
        push      = 1'b0;
        pop       = 1'b0;

        if (mem_wr) begin
            w_en_d   = 1'b1;
            w_idx_d  = i_mem_rd;
            w_data_d = i_mem_load ? mem_fmt : i_mem_rd_reg;
        end else if (!buf_empty) begin
            pop      = 1'b1;
            w_en_d   = 1'b1;
            w_idx_d  = buf_rd_q[rptr_q];
            w_data_d = buf_res_q[rptr_q];
        end

        // x0 results complete the handshake but are never stored or written.
        if (md_fire && (i_md_rd != '0)) begin
            if (!mem_wr && buf_empty) begin
                w_en_d   = 1'b1;
                w_idx_d  = i_md_rd;
                w_data_d = i_md_result;
            end else begin
                push = 1'b1;
            end
        end

        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        pending_d = (count_d != '0);
        instret_d = instret_q + CNT_W'(i_mem_valid);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            w_en_q    <= 1'b0;
            w_idx_q   <= '0;
            w_data_q  <= '0;
            instret_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            w_en_q    <= w_en_d;
            w_idx_q   <= w_idx_d;
            w_data_q  <= w_data_d;
            instret_q <= instret_d;
        end
    end

    // Buffer payload needs no reset; occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_rd_q[wptr_q]  <= i_md_rd;
            buf_res_q[wptr_q] <= i_md_result;
        end
    end

    assign o_reg_w_en   = w_en_q;
    assign o_reg_w      = w_idx_q;
    assign o_reg_w_reg  = w_data_q;
    assign o_md_pending = pending_q;
    assign o_instret    = instret_q;

endmodule

// File: tb/tb_nnrv_wb_ext.sv
module tb_nnrv_wb_ext;
  import nnrv_wb_pkg::*;

  localparam int XLEN     = 64;
  localparam int MD_DEPTH = 2;
  localparam int CNT_W    = 4;
  localparam int AW       = 3;
  localparam int RW       = REG_IDX_W + XLEN;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  logic                 i_mem_valid = 0;
  logic                 i_mem_rd_en = 0;
  logic [4:0]           i_mem_rd = 0;
  logic [XLEN-1:0]      i_mem_rd_reg = 0;
  logic                 i_mem_load = 0;
  logic [1:0]           i_mem_lsize = 0;
  logic                 i_mem_lunsigned = 0;
  logic [AW-1:0]        i_mem_addr_lo = 0;
  logic                 i_md_valid = 0;
  logic                 o_md_ready;
  logic [4:0]           i_md_rd = 0;
  logic [XLEN-1:0]      i_md_result = 0;
  logic                 o_reg_w_en;
  logic [4:0]           o_reg_w;
  logic [XLEN-1:0]      o_reg_w_reg;
  logic                 o_md_pending;
  logic [CNT_W-1:0]     o_instret;

  nnrv_wb_ext #(.XLEN(XLEN), .MD_DEPTH(MD_DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mem_valid(i_mem_valid), .i_mem_rd_en(i_mem_rd_en), .i_mem_rd(i_mem_rd),
    .i_mem_rd_reg(i_mem_rd_reg), .i_mem_load(i_mem_load), .i_mem_lsize(i_mem_lsize),
    .i_mem_lunsigned(i_mem_lunsigned), .i_mem_addr_lo(i_mem_addr_lo),
    .i_md_valid(i_md_valid), .o_md_ready(o_md_ready), .i_md_rd(i_md_rd),
    .i_md_result(i_md_result), .o_reg_w_en(o_reg_w_en), .o_reg_w(o_reg_w),
    .o_reg_w_reg(o_reg_w_reg), .o_md_pending(o_md_pending), .o_instret(o_instret)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0]    exp_q[$];   // expected writes, popped when the DUT writes
  logic [RW-1:0]    md_buf[$];  // model of the mul/div buffer
  logic [RW-1:0]    md_off[$];  // mul/div results waiting to be offered
  logic [RW-1:0]    last_w = '0;
  logic [CNT_W-1:0] exp_instret = '0;
  logic [XLEN-1:0]  mem_exp = '0;

  typedef struct {
    logic [XLEN-1:0] raw;
    logic [AW-1:0]   addr_lo;
    logic [1:0]      lsize;
    logic            uns;
    logic            load;
    logic [XLEN-1:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_mem(input logic v, input logic en, input logic [4:0] rd,
                         input logic [XLEN-1:0] data);
    i_mem_valid = v; i_mem_rd_en = en; i_mem_rd = rd; i_mem_rd_reg = data;
    i_mem_load = 0; i_mem_lsize = 0; i_mem_lunsigned = 0; i_mem_addr_lo = 0;
    mem_exp = data;
  endtask

  // One clock: offer the next md result, predict the cycle, then check.
  task automatic step();
    logic exp_ready, md_fire, md_keep, mem_wr, have_w;
    logic [RW-1:0] w, tmp;
    if (md_off.size() > 0) begin
      i_md_valid = 1'b1;
      {i_md_rd, i_md_result} = md_off[0];
    end else begin
      i_md_valid = 1'b0;
    end
    exp_ready = (md_buf.size() < MD_DEPTH);
    check("md_ready", o_md_ready, exp_ready);
    md_fire = i_md_valid && exp_ready;
    md_keep = md_fire && (i_md_rd != 0);
    mem_wr  = i_mem_valid && i_mem_rd_en && (i_mem_rd != 0);
    have_w  = 1'b1;
    w       = '0;
    if (mem_wr) w = {i_mem_rd, mem_exp};
    else if (md_buf.size() > 0) w = md_buf.pop_front();
    else if (md_keep) begin
      w = {i_md_rd, i_md_result};
      md_keep = 1'b0;
    end else have_w = 1'b0;
    if (md_keep) md_buf.push_back({i_md_rd, i_md_result});
    if (md_fire) tmp = md_off.pop_front();
    if (i_mem_valid) exp_instret++;
    if (have_w) exp_q.push_back(w);

    @(posedge i_clk);
    #1;
    check("reg_w_en", o_reg_w_en, have_w);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("reg_w", {o_reg_w, o_reg_w_reg}, w);
      last_w = w;
    end else begin
      check("reg_w_hold", {o_reg_w, o_reg_w_reg}, last_w);
    end
    check("instret", o_instret, exp_instret);
    check("md_pending", o_md_pending, md_buf.size() != 0);
  endtask

  task automatic drain();
    set_mem(0, 0, 0, '0);
    for (int k = 0; k < 8 && (md_buf.size() > 0 || md_off.size() > 0); k++) step();
    check("drained", md_buf.size() + md_off.size(), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{64'h8877_6655_4433_2211, 3'd3, 2'd0, 1'b0, 1'b1, 64'h44};
    vecs[1]  = '{64'h8877_6655_4433_2211, 3'd7, 2'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF88};
    vecs[2]  = '{64'h8877_6655_4433_2211, 3'd4, 2'd1, 1'b1, 1'b1, 64'h6655};
    vecs[3]  = '{64'h8877_6655_4433_2211, 3'd4, 2'd2, 1'b0, 1'b1, 64'hFFFF_FFFF_8877_6655};
    vecs[4]  = '{64'h8877_6655_4433_2211, 3'd0, 2'd3, 1'b0, 1'b1, 64'h8877_6655_4433_2211};
    vecs[5]  = '{64'h8877_6655_4433_2211, 3'd7, 2'd0, 1'b1, 1'b1, 64'h88};
    vecs[6]  = '{64'h8877_6655_4433_2211, 3'd6, 2'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8877};
    vecs[7]  = '{64'h8877_6655_4433_2211, 3'd0, 2'd2, 1'b1, 1'b1, 64'h4433_2211};
    vecs[8]  = '{64'h8877_6655_4433_2211, 3'd2, 2'd3, 1'b1, 1'b1, 64'h0000_8877_6655_4433};
    vecs[9]  = '{64'h8877_6655_4433_2211, 3'd1, 2'd1, 1'b0, 1'b1, 64'h3322};
    vecs[10] = '{64'h8877_6655_4433_2211, 3'd5, 2'd2, 1'b0, 1'b1, 64'h0088_7766};
    vecs[11] = '{64'h8877_6655_4433_2211, 3'd7, 2'd0, 1'b0, 1'b0, 64'h8877_6655_4433_2211};

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_w_en", o_reg_w_en, 0);
    check("rst_w", {o_reg_w, o_reg_w_reg}, 0);
    check("rst_instret", o_instret, 0);
    check("rst_pending", o_md_pending, 0);
    i_rst = 1'b0;

    // Load formatting table
    for (int i = 0; i < 12; i++) begin
      i_mem_valid = 1; i_mem_rd_en = 1; i_mem_rd = 5'(i + 1);
      i_mem_rd_reg = vecs[i].raw; i_mem_load = vecs[i].load;
      i_mem_lsize = vecs[i].lsize; i_mem_lunsigned = vecs[i].uns;
      i_mem_addr_lo = vecs[i].addr_lo;
      mem_exp = vecs[i].exp;
      step();
    end
    set_mem(0, 0, 0, '0);
    step();

    // Bypass, x0 md drop, x0 mem write
    md_off.push_back({5'd9, 64'h55});
    step();
    step();
    md_off.push_back({5'd0, 64'h99});
    step();
    check("x0_md_taken", md_off.size(), 0);
    set_mem(1, 1, 0, 64'h77);
    step();
    set_mem(0, 0, 0, '0);
    step();

    // Collision: mem x5 for 4 cycles while md offers x7 then x8
    md_off.push_back({5'd7, 64'hA});
    md_off.push_back({5'd8, 64'hB});
    for (int i = 0; i < 4; i++) begin
      set_mem(1, 1, 5'd5, 64'h100 + 64'(i));
      step();
    end
    drain();

    // Backpressure: continuous mem writes with three md offers
    md_off.push_back({5'd10, 64'hC0});
    md_off.push_back({5'd11, 64'hC1});
    md_off.push_back({5'd12, 64'hC2});
    for (int i = 0; i < 6; i++) begin
      set_mem(1, 1, 5'd6, 64'h200 + 64'(i));
      step();
    end
    check("bp_held", md_off.size(), 1);
    drain();

    // Random mix
    for (int i = 0; i < 150; i++) begin
      set_mem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), {$urandom, $urandom});
      if (md_off.size() == 0 && $urandom_range(0, 2) == 0)
        md_off.push_back({5'($urandom_range(0, 31)), {$urandom, $urandom}});
      step();
    end
    drain();

    // Reset mid-stream with two results buffered
    md_off.push_back({5'd20, 64'hD0});
    md_off.push_back({5'd21, 64'hD1});
    for (int i = 0; i < 2; i++) begin
      set_mem(1, 1, 5'd4, 64'h300 + 64'(i));
      step();
    end
    check("pre_rst_buf", md_buf.size(), 2);
    set_mem(0, 0, 0, '0);
    #3 i_rst = 1'b1;
    #1;
    check("mrst_w_en", o_reg_w_en, 0);
    check("mrst_w", {o_reg_w, o_reg_w_reg}, 0);
    check("mrst_instret", o_instret, 0);
    check("mrst_pending", o_md_pending, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    md_buf.delete(); exp_q.delete(); md_off.delete();
    last_w = '0; exp_instret = '0;
    for (int i = 0; i < 3; i++) step();

    // Counter wrap: 17 retirements with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      set_mem(1, 0, 5'd3, 64'h1);
      step();
    end
    check("instret_wrap", o_instret, 4'd1);
    set_mem(0, 0, 0, '0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
